// File: rtl/ci_fft_feeder.sv
// FFT input feeder: buffers raw ADC samples in a small FIFO and emits them as
// real-only signed complex words, rate-limited and grouped into tagged frames.
module ci_fft_feeder #(
   parameter int DATLEN          = 12,
   parameter int FFT_LEN         = 16,
   parameter int FFT_LEN_LOG2    = 4,
   parameter int FIFO_DEPTH      = 8,
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int MIN_GAP         = 2,
   parameter int OFFSET_BIN      = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       adc_nd,
   input  logic [DATLEN-1:0]          adc_x,
   output logic                       fft_nd,
   output logic [0:2*DATLEN-1]        fft_x,
   output logic                       frame_start,
   output logic [FFT_LEN_LOG2-1:0]    sample_idx,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
   output logic                       drop,
   output logic [7:0]                 drop_count
);

   localparam int GAP_W = $clog2(MIN_GAP) + 1;
   localparam logic [GAP_W-1:0]          GAP_RELOAD = GAP_W'(MIN_GAP - 1);
   localparam logic [FIFO_DEPTH_LOG2:0]  FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);
   localparam logic [FFT_LEN_LOG2-1:0]   LAST_IDX   = FFT_LEN_LOG2'(FFT_LEN - 1);

   typedef enum logic {IDLE, RUN} state_t;

   // Offset-binary ADC codes become two's complement by flipping the MSB.
   function automatic logic signed [DATLEN-1:0] to_real(input logic [DATLEN-1:0] x);
      if (OFFSET_BIN != 0)
         return $signed({~x[DATLEN-1], x[DATLEN-2:0]});
      else
         return $signed(x);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic                        adc_nd_p0;
   logic [DATLEN-1:0]           adc_x_p0;
   logic [DATLEN-1:0]           mem [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
   logic [GAP_W-1:0]            gap_cnt;
   state_t                      state;
   logic [FFT_LEN_LOG2-1:0]     next_idx;
   logic                        fifo_empty;
   logic                        fifo_full;
   logic                        gap_ok;
   logic                        wr_en;
   logic                        drop_en;
   logic                        emit;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == FULL_LEVEL);
   assign gap_ok     = (gap_cnt == '0);
   assign wr_en      = adc_nd_p0 && !fifo_full;
   assign drop_en    = adc_nd_p0 && fifo_full;
   assign emit       = !fifo_empty && gap_ok && ((state == RUN) || enable);
   assign next_idx   = sample_idx + 1'b1;

   // Stage p0: register the ADC strobe/sample before the FIFO write port
   always_ff @(posedge clk) begin
      adc_x_p0 <= adc_x;
      if (wr_en)
         mem[wr_ptr] <= adc_x_p0;
   end

   // Stage p1: FIFO bookkeeping, rate limiting, framing FSM and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         adc_nd_p0   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         drop        <= 1'b0;
         drop_count  <= '0;
         gap_cnt     <= '0;
         state       <= IDLE;
         fft_nd      <= 1'b0;
         fft_x       <= '0;
         frame_start <= 1'b0;
         sample_idx  <= '0;
      end else begin
         adc_nd_p0 <= adc_nd;
         drop      <= drop_en;
         if (drop_en)
            drop_count <= sat_inc8(drop_count);

         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (emit)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, emit})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase

         if (emit)
            gap_cnt <= GAP_RELOAD;
         else if (!gap_ok)
            gap_cnt <= gap_cnt - 1'b1;

         fft_nd      <= emit;
         frame_start <= 1'b0;
         if (emit)
            fft_x <= {to_real(mem[rd_ptr]), {DATLEN{1'b0}}};

         case (state)
            IDLE: begin
               sample_idx <= '0;
               if (emit) begin
                  frame_start <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               // enable is deliberately ignored here so a started frame always completes
               if (emit) begin
                  sample_idx <= next_idx;
                  if (next_idx == LAST_IDX)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ci_fft_feeder.sv
// Directed bench for ci_fft_feeder: table-driven frame check plus hand-written
// sequences for overflow, enable gating, mid-frame reset and drop saturation.
module tb_ci_fft_feeder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, enable = 1'b0, adc_nd = 1'b0;
   logic [11:0] adc_x = '0;
   logic        fft_nd, frame_start, drop;
   logic [0:23] fft_x;
   logic [3:0]  sample_idx, fifo_level;
   logic [7:0]  drop_count;

   logic        r_reset = 1'b1, r_enable = 1'b0, r_adc_nd = 1'b0;
   logic [11:0] r_adc_x = '0;
   logic        r_fft_nd, r_frame_start, r_drop;
   logic [0:23] r_fft_x;
   logic [3:0]  r_sample_idx, r_fifo_level;
   logic [7:0]  r_drop_count;

   ci_fft_feeder dut (
      .clk(clk), .reset(reset), .enable(enable), .adc_nd(adc_nd), .adc_x(adc_x),
      .fft_nd(fft_nd), .fft_x(fft_x), .frame_start(frame_start), .sample_idx(sample_idx),
      .fifo_level(fifo_level), .drop(drop), .drop_count(drop_count));

   ci_fft_feeder #(.OFFSET_BIN(0)) dut_raw (
      .clk(clk), .reset(r_reset), .enable(r_enable), .adc_nd(r_adc_nd), .adc_x(r_adc_x),
      .fft_nd(r_fft_nd), .fft_x(r_fft_x), .frame_start(r_frame_start), .sample_idx(r_sample_idx),
      .fifo_level(r_fifo_level), .drop(r_drop), .drop_count(r_drop_count));

   typedef struct {
      logic [11:0] x;
      logic [11:0] real_v;
      logic [3:0]  idx;
      logic        fs;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   logic [11:0] mon_real[$];
   logic [11:0] mon_imag[$];
   logic [3:0]  mon_idx[$];
   logic        mon_fs[$];
   int          consec_cnt  = 0;
   int          drop_pulses = 0;
   logic        prev_nd     = 1'b0;

   always @(negedge clk) begin
      if (fft_nd) begin
         mon_real.push_back(fft_x[0:11]);
         mon_imag.push_back(fft_x[12:23]);
         mon_idx.push_back(sample_idx);
         mon_fs.push_back(frame_start);
      end
      if (fft_nd && prev_nd) consec_cnt++;
      prev_nd = fft_nd;
      if (drop) drop_pulses++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; adc_nd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push(input logic [11:0] x);
      adc_nd = 1'b1; adc_x = x;
      @(negedge clk);
      adc_nd = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_emit(input string name, input int pos, input logic [11:0] re,
                             input logic [3:0] idx, input logic fs);
      if (pos < mon_real.size()) begin
         check({name, " real"}, 32'(mon_real[pos]), 32'(re));
         check({name, " imag"}, 32'(mon_imag[pos]), 32'h0);
         check({name, " idx"},  32'(mon_idx[pos]),  32'(idx));
         check({name, " fs"},   32'(mon_fs[pos]),   32'(fs));
      end else begin
         check({name, " present"}, 32'(mon_real.size()), 32'(pos + 1));
      end
   endtask

   vec_t        vecs[16];
   logic [11:0] exp_q[$];
   int          b, db, c0;
   bit          found;

   initial begin
      for (int i = 0; i < 16; i++)
         vecs[i] = '{x: 12'h800 + 12'(i), real_v: 12'(i), idx: 4'(i), fs: (i == 0)};

      // reset state
      do_reset();
      r_reset = 1'b0;
      check("rst fft_nd",      32'(fft_nd),      32'h0);
      check("rst fft_x",       32'(fft_x),       32'h0);
      check("rst frame_start", 32'(frame_start), 32'h0);
      check("rst sample_idx",  32'(sample_idx),  32'h0);
      check("rst fifo_level",  32'(fifo_level),  32'h0);
      check("rst drop",        32'(drop),        32'h0);
      check("rst drop_count",  32'(drop_count),  32'h0);

      // latency: strobe sampled at edge E0, fft_nd visible after E2
      enable = 1'b1; adc_nd = 1'b1; adc_x = 12'h123;
      @(negedge clk);
      adc_nd = 1'b0;
      check("lat after E0", 32'(fft_nd), 32'h0);
      @(negedge clk);
      check("lat after E1", 32'(fft_nd), 32'h0);
      @(negedge clk);
      check("lat after E2", 32'(fft_nd), 32'h1);
      check("lat real", 32'(fft_x[0:11]), 32'h923);

      // table-driven full frame, one sample every 2 cycles
      do_reset();
      enable = 1'b1;
      b = mon_real.size();
      for (int i = 0; i < 16; i++) push(vecs[i].x);
      idle(10);
      check("frame count", 32'(mon_real.size() - b), 32'd16);
      for (int i = 0; i < 16; i++)
         check_emit($sformatf("frame[%0d]", i), b + i, vecs[i].real_v, vecs[i].idx, vecs[i].fs);

      // adc_nd held 20 cycles: FIFO overflows, samples 15,17,19 dropped
      do_reset();
      enable = 1'b1;
      b = mon_real.size(); db = drop_pulses; c0 = consec_cnt;
      for (int i = 0; i < 20; i++) begin
         adc_nd = 1'b1; adc_x = 12'(i);
         @(negedge clk);
      end
      adc_nd = 1'b0;
      idle(50);
      exp_q.delete();
      for (int i = 0; i < 15; i++) exp_q.push_back(12'(i) ^ 12'h800);
      exp_q.push_back(12'h810);
      exp_q.push_back(12'h812);
      check("burst no consecutive nd", 32'(consec_cnt - c0), 32'd0);
      check("burst drop_count",  32'(drop_count), 32'd3);
      check("burst drop pulses", 32'(drop_pulses - db), 32'd3);
      check("burst emitted",     32'(mon_real.size() - b), 32'd17);
      check("burst fifo drained", 32'(fifo_level), 32'd0);
      for (int i = 0; i < 17; i++)
         check_emit($sformatf("burst[%0d]", i), b + i, exp_q[i], 4'(i), (i == 0) || (i == 16));

      // enable low with 5 queued: nothing emitted until enable rises
      do_reset();
      b = mon_real.size();
      for (int i = 0; i < 5; i++) push(12'h80A + 12'(i));
      idle(5);
      check("gated no nd", 32'(mon_real.size() - b), 32'd0);
      check("gated level", 32'(fifo_level), 32'd5);
      enable = 1'b1;
      idle(20);
      check("gated emitted", 32'(mon_real.size() - b), 32'd5);
      check_emit("gated first", b, 12'h00A, 4'd0, 1'b1);
      check_emit("gated last",  b + 4, 12'h00E, 4'd4, 1'b0);

      // enable dropped mid-frame: frame completes, then stalls in IDLE
      do_reset();
      enable = 1'b1;
      b = mon_real.size();
      for (int i = 0; i < 20; i++) begin
         push(12'h800 + 12'(i));
         if (mon_real.size() - b >= 8) enable = 1'b0;
      end
      idle(20);
      check("midoff count", 32'(mon_real.size() - b), 32'd16);
      for (int i = 8; i < 16; i++)
         check_emit($sformatf("midoff[%0d]", i), b + i, 12'(i), 4'(i), 1'b0);
      check("midoff level", 32'(fifo_level), 32'd4);
      enable = 1'b1;
      idle(20);
      check("midoff resume count", 32'(mon_real.size() - b), 32'd20);
      check_emit("midoff resume", b + 16, 12'h010, 4'd0, 1'b1);

      // reset while sample 5 is on the output with 3 entries still queued
      do_reset();
      for (int i = 0; i < 8; i++) push(12'h800 + 12'(i));
      idle(3);
      check("prefill level", 32'(fifo_level), 32'd8);
      enable = 1'b1; adc_nd = 1'b1; adc_x = 12'h8AA;
      @(negedge clk);
      adc_nd = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (fft_nd && sample_idx == 4'd5) found = 1'b1;
         else @(negedge clk);
      end
      check("midrst reached idx5", 32'(found), 32'h1);
      check("midrst level at idx5", 32'(fifo_level), 32'd3);
      reset = 1'b1;
      @(negedge clk);
      check("midrst fft_nd",      32'(fft_nd),      32'h0);
      check("midrst fft_x",       32'(fft_x),       32'h0);
      check("midrst frame_start", 32'(frame_start), 32'h0);
      check("midrst sample_idx",  32'(sample_idx),  32'h0);
      check("midrst fifo_level",  32'(fifo_level),  32'h0);
      reset = 1'b0; enable = 1'b1;
      b = mon_real.size();
      push(12'h805);
      idle(6);
      check("midrst restart count", 32'(mon_real.size() - b), 32'd1);
      check_emit("midrst restart", b, 12'h005, 4'd0, 1'b1);

      // pass-through instance: 310 cycles of strobes with enable low, then release
      r_adc_nd = 1'b1; r_adc_x = 12'hFFF;
      idle(310);
      r_adc_nd = 1'b0;
      idle(2);
      check("raw drop_count sat", 32'(r_drop_count), 32'd255);
      check("raw level full",     32'(r_fifo_level), 32'd8);
      r_enable = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (r_fft_nd) found = 1'b1;
      end
      check("raw emitted", 32'(found), 32'h1);
      check("raw fft_x",   32'(r_fft_x), 32'h00FFF000);
      check("raw frame_start", 32'(r_frame_start), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
